// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and grant-to-select helper for the mux round-robin arbiter.
package mux_arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {IDLE, BUSY} arb_state_e;

   function automatic logic [SEL_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after start, wrapping modulo N_REQ.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] start,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         // SEL_W-bit addition wraps naturally because N_REQ == 2**SEL_W
         cand = start + SEL_W'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with per-grant tenure limit.
// Optional MUX_ARB_LOCK_EN adds a lock input that suppresses the tenure timeout.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
`ifdef MUX_ARB_LOCK_EN
   input  logic             lock,
`endif
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [SEL_W-1:0] sel,
   output logic             gnt_valid,
   output logic             owner_tout
);

   localparam int unsigned      CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [SEL_W-1:0] last_ptr_q, last_ptr_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             owner_tout_q, owner_tout_d;

   logic [N_REQ-1:0] others, pick_req;
   logic [SEL_W-1:0] pick_start, pick_idx;
   logic             pick_found, owner_req, at_limit, lock_hold, timeout, release_g;

`ifdef MUX_ARB_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   // last_ptr always holds the current/previous owner, so both searches start one past it
   assign others     = req & ~grant_q;
   assign pick_req   = (state_q == BUSY) ? others : req;
   assign pick_start = last_ptr_q + SEL_W'(1);
   assign owner_req  = |(req & grant_q);
   assign at_limit   = (hold_cnt_q == HOLD_LAST);
   assign timeout    = (state_q == BUSY) && owner_req && at_limit && !lock_hold && (|others);
   assign release_g  = (state_q == BUSY) && (!owner_req || timeout);

   rr_pick u_pick (
      .req   (pick_req),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_cnt_q   <= '0;
         last_ptr_q   <= '1;
         grant_q      <= '0;
         sel_q        <= '0;
         gnt_valid_q  <= 1'b0;
         owner_tout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         last_ptr_q   <= last_ptr_d;
         grant_q      <= grant_d;
         sel_q        <= sel_d;
         gnt_valid_q  <= gnt_valid_d;
         owner_tout_q <= owner_tout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      last_ptr_d = last_ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d    = BUSY;
               hold_cnt_d = '0;
               last_ptr_d = pick_idx;
            end
         end
         BUSY: begin
            if (release_g) begin
               hold_cnt_d = '0;
               if (pick_found) begin
                  last_ptr_d = pick_idx;
               end else begin
                  state_d = IDLE;
               end
            end else if (!lock_hold) begin
               // uncontended tenure limit simply restarts the count
               hold_cnt_d = at_limit ? '0 : hold_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d      = grant_q;
      sel_d        = sel_q;
      gnt_valid_d  = gnt_valid_q;
      owner_tout_d = 1'b0;
      if ((state_q == IDLE) || release_g) begin
         if (pick_found) begin
            grant_d      = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            sel_d        = onehot2idx(grant_d);
            gnt_valid_d  = 1'b1;
            owner_tout_d = timeout;
         end else begin
            grant_d     = '0;
            gnt_valid_d = 1'b0;
         end
      end
   end

   assign grant      = grant_q;
   assign sel        = sel_q;
   assign gnt_valid  = gnt_valid_q;
   assign owner_tout = owner_tout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: MAX_HOLD=8 instance (a) and MAX_HOLD=1 instance (b).
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_a, req_b;
   logic       lock_a, lock_b;
   logic [3:0] grant_a, grant_b;
   logic [1:0] sel_a, sel_b;
   logic       vld_a, vld_b, tout_a, tout_b;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      int         dut;
      logic [3:0] g;
      logic [1:0] s;
      logic       v;
      logic       t;
      logic       sc;
      string      tag;
   } exp_t;

   exp_t q[$];
   exp_t e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mux_rr_arbiter #(.MAX_HOLD(8)) dut_a (
      .clk        (clk),
      .rst        (rst),
`ifdef MUX_ARB_LOCK_EN
      .lock       (lock_a),
`endif
      .req        (req_a),
      .grant      (grant_a),
      .sel        (sel_a),
      .gnt_valid  (vld_a),
      .owner_tout (tout_a)
   );

   mux_rr_arbiter #(.MAX_HOLD(1)) dut_b (
      .clk        (clk),
      .rst        (rst),
`ifdef MUX_ARB_LOCK_EN
      .lock       (lock_b),
`endif
      .req        (req_b),
      .grant      (grant_b),
      .sel        (sel_b),
      .gnt_valid  (vld_b),
      .owner_tout (tout_b)
   );

   // monitor: compares every expectation due at this cycle
   always @(negedge clk) begin
      logic [7:0] act, req_v;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         if (e.dut == 0) act = {grant_a, sel_a, vld_a, tout_a};
         else            act = {grant_b, sel_b, vld_b, tout_b};
         req_v = {e.g, e.s, e.v, e.t};
         if (!e.sc) begin
            act[3:2]   = 2'b00;
            req_v[3:2] = 2'b00;
         end
         checks++;
         if (act !== req_v) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got grant=%b sel=%b vld=%b tout=%b, expected grant=%b sel=%b vld=%b tout=%b",
                     e.tag, e.dut, cyc, act[7:4], act[3:2], act[1], act[0],
                     req_v[7:4], req_v[3:2], req_v[1], req_v[0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int dut, input logic [3:0] g, input logic [1:0] s,
                       input logic v, input logic t, input logic sc, input string tag);
      exp_t x;
      x.cyc = cyc + 1;
      x.dut = dut;
      x.g   = g;
      x.s   = s;
      x.v   = v;
      x.t   = t;
      x.sc  = sc;
      x.tag = tag;
      q.push_back(x);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_a = '0; req_b = '0; lock_a = 1'b0; lock_b = 1'b0;
      for (int i = 0; i < 2; i++) begin
         push(0, 4'b0000, 2'd0, 0, 0, 1, "reset_a");
         push(1, 4'b0000, 2'd0, 0, 0, 1, "reset_b");
         tick();
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(0, 4'b0000, 2'd0, 0, 0, 1, "idle_a");
         push(1, 4'b0000, 2'd0, 0, 0, 1, "idle_b");
         tick();
      end

      req_a = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         push(0, 4'b0100, 2'd2, 1, 0, 1, "single");
         tick();
      end
      req_a = 4'b0000;
      push(0, 4'b0000, 2'd2, 0, 0, 1, "single_drop");
      tick();

      req_a = 4'b1000;
      for (int i = 0; i < 20; i++) begin
         push(0, 4'b1000, 2'd3, 1, 0, 1, "solo");
         tick();
      end
      req_a = 4'b0000;
      push(0, 4'b0000, 2'd3, 0, 0, 1, "solo_drop");
      tick();

      req_a = 4'b0011;
      for (int i = 0; i < 17; i++) begin
         if (i < 8)       push(0, 4'b0001, 2'd0, 1, 0, 1, "tout_r0");
         else if (i < 16) push(0, 4'b0010, 2'd1, 1, (i == 8), 1, "tout_r1");
         else             push(0, 4'b0001, 2'd0, 1, 1, 1, "tout_back");
         tick();
      end
      for (int i = 0; i < 7; i++) begin
         push(0, 4'b0001, 2'd0, 1, 0, 1, "tout_hold");
         tick();
      end
      req_a = 4'b0010;
      push(0, 4'b0010, 2'd1, 1, 0, 1, "rel_at_limit");
      tick();
      req_a = 4'b0000;
      push(0, 4'b0000, 2'd1, 0, 0, 1, "rel_drop");
      tick();

      req_a = 4'b0010;
      for (int i = 0; i < 2; i++) begin
         push(0, 4'b0010, 2'd1, 1, 0, 1, "pre_reset");
         tick();
      end
      rst = 1'b1; req_a = 4'b1111;
      push(0, 4'b0000, 2'd0, 0, 0, 1, "mid_reset_a");
      push(1, 4'b0000, 2'd0, 0, 0, 1, "mid_reset_b");
      tick();
      rst = 1'b0;
      push(0, 4'b0001, 2'd0, 1, 0, 1, "post_reset");
      tick();
      req_a = 4'b0000;
      push(0, 4'b0000, 2'd0, 0, 0, 1, "post_reset_idle");
      tick();

`ifdef MUX_ARB_LOCK_EN
      lock_a = 1'b1; req_a = 4'b0011;
      for (int i = 0; i < 12; i++) begin
         push(0, 4'b0010, 2'd1, 1, 0, 1, "lock_hold");
         tick();
      end
      lock_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < 7) push(0, 4'b0010, 2'd1, 1, 0, 1, "unlock_count");
         else       push(0, 4'b0001, 2'd0, 1, 1, 1, "unlock_tout");
         tick();
      end
      req_a = 4'b0000;
      push(0, 4'b0000, 2'd0, 0, 0, 1, "lock_idle");
      tick();
`endif

      req_b = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         push(1, 4'(1 << (i % 4)), 2'(i % 4), 1, (i != 0), 1, "rotate");
         tick();
      end
      req_b = 4'b0000;
      push(1, 4'b0000, 2'd0, 0, 0, 1, "rotate_drop");
      tick();
      req_b = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         push(1, 4'b0100, 2'd2, 1, 0, 1, "hold1_solo");
         tick();
      end
      req_b = 4'b0000;
      push(1, 4'b0000, 2'd2, 0, 0, 1, "hold1_drop");
      tick();

      @(negedge clk);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         $display("FAIL drain: %0d expectations never compared, expected 0", q.size());
         errors += q.size();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
